// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry, colour constants, line-clear FSM encoding and score table
package tetris_pkg;
  localparam int COLOR_W = 24;
  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;
  localparam int ROW_AW = 5;
  localparam logic [COLOR_W-1:0] EMPTY_COLOR = '0;
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(BOARD_ROWS - 1);
  typedef enum logic [2:0] {IDLE, RD, WT, EV, WR, CLR, DN} clr_state_t;
  function automatic logic [10:0] line_score(input logic [2:0] n);
    return n == 3'd1 ? 11'd40 : n == 3'd2 ? 11'd100 : n == 3'd3 ? 11'd300 : n == 3'd4 ? 11'd1200 : 11'd0;
  endfunction
endpackage

// File: rtl/board_row_full.sv
// board_row_full: flags a board row whose every column holds a non-empty colour
module board_row_full
  import tetris_pkg::*;
(
  input  logic [BOARD_COLS*COLOR_W-1:0] row,
  output logic                          full
);
  // AND-reduce the per-column occupancy
  always_comb begin
    full = 1'b1;
    for (int c = 0; c < BOARD_COLS; c++) full = full && (row[c*COLOR_W +: COLOR_W] != EMPTY_COLOR);
  end
endmodule

// File: rtl/board_line_clearer.sv
// board_line_clearer: removes full rows, compacts the board downwards and blanks the vacated top rows (scoring via LINE_CLEAR_SCORE_EN)
module board_line_clearer
  import tetris_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    lines_cleared,
  output logic [ROW_AW-1:0]             ram_row,
  input  logic [BOARD_COLS*COLOR_W-1:0] ram_rd_data,
  output logic [BOARD_COLS*COLOR_W-1:0] ram_wr_data,
  output logic [BOARD_COLS-1:0]         ram_we
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [10:0]                   score_add
`endif
);
  clr_state_t state, tail_state;
  logic [ROW_AW-1:0] src, dst, dst_n, tail_row;
  logic full, dec, borrow, copy;
  board_row_full u_full (.row(ram_rd_data), .full(full));
  // dst moves down whenever a surviving row is placed; borrow flags a step below row 0
  always_comb begin
    copy = state == EV && !full && src != dst;
    dec = state == WR || (state == EV && !full && src == dst);
    dst_n = dec ? dst - 1'b1 : dst;
    borrow = dec && dst == '0;
    tail_state = src == '0 ? (borrow ? DN : CLR) : RD;
    tail_row = src == '0 ? (borrow ? '0 : dst_n) : src - 1'b1;
  end
  // scan/compact/clear sequencer with registered RAM controls
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      lines_cleared <= '0;
      ram_row <= '0;
      ram_wr_data <= '0;
      ram_we <= '0;
      src <= '0;
      dst <= '0;
`ifdef LINE_CLEAR_SCORE_EN
      score_add <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
          score_add <= '0;
`endif
          if (start) begin
            busy <= 1'b1;
            src <= LAST_ROW;
            dst <= LAST_ROW;
            ram_row <= LAST_ROW;
            lines_cleared <= '0;
            state <= RD;
          end
        end
        RD: state <= WT;
        WT: state <= EV;
        EV, WR: begin
          if (state == EV && full) lines_cleared <= lines_cleared == 3'd4 ? 3'd4 : lines_cleared + 3'd1;
          if (copy) begin
            ram_row <= dst;
            ram_wr_data <= ram_rd_data;
            ram_we <= '1;
            state <= WR;
          end else begin
            ram_row <= tail_row;
            ram_wr_data <= '0;
            ram_we <= tail_state == CLR ? '1 : '0;
            dst <= dst_n;
            src <= src == '0 ? src : src - 1'b1;
            state <= tail_state;
          end
        end
        CLR: begin
          if (dst == '0) begin
            ram_we <= '0;
            state <= DN;
          end else begin
            dst <= dst - 1'b1;
            ram_row <= dst - 1'b1;
          end
        end
        DN: begin
          done <= 1'b1;
          busy <= 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
          score_add <= line_score(lines_cleared);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_line_clearer.sv
// tb_board_line_clearer: directed checks of row removal, compaction, timing and reset behaviour
module tb_board_line_clearer;
  import tetris_pkg::*;
  localparam int W = BOARD_COLS * COLOR_W;
  localparam logic [W-1:0] FULL = {BOARD_COLS{24'h5C5C5C}};
  localparam logic [W-1:0] ROW_M = {216'd0, 24'h3EB489};
  localparam logic [W-1:0] ROW_A = {24'h000000, {9{24'h112233}}};
  localparam logic [W-1:0] ROW_B = {{9{24'h445566}}, 24'h000000};
  localparam logic [W-1:0] ROW_P = {24'hABCDEF, 24'h000000, {8{24'h010203}}};
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done;
  logic [2:0] lines_cleared, lc_done;
  logic [ROW_AW-1:0] ram_row;
  logic [W-1:0] rd, ram_wr_data;
  logic [BOARD_COLS-1:0] ram_we;
  logic [10:0] score_add, sc_done;
  logic [W-1:0] mem [32];
  logic ld_en = 1'b0, ld_clr = 1'b0;
  logic [4:0] ld_row = '0;
  logic [W-1:0] ld_data = '0;
  int checks = 0, fails = 0, done_k, dcnt, wcnt;
`ifndef LINE_CLEAR_SCORE_EN
  assign score_add = '0;
`endif
  board_line_clearer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .ram_row(ram_row), .ram_rd_data(rd),
    .ram_wr_data(ram_wr_data), .ram_we(ram_we)
`ifdef LINE_CLEAR_SCORE_EN
    , .score_add(score_add)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ld_clr) for (int r = 0; r < 32; r++) mem[r] <= '0;
    else if (ld_en) mem[ld_row] <= ld_data;
    else for (int c = 0; c < BOARD_COLS; c++) if (ram_we[c]) mem[ram_row][c*COLOR_W +: COLOR_W] <= ram_wr_data[c*COLOR_W +: COLOR_W];
    rd <= mem[ram_row];
  end
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wipe();
    ld_clr = 1'b1;
    @(posedge clk);
    #1 ld_clr = 1'b0;
  endtask
  task automatic put(input int r, input logic [W-1:0] d);
    ld_row = r[4:0];
    ld_data = d;
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask
  function automatic int nonempty(input int hi);
    int n = 0;
    for (int r = 0; r <= hi; r++) if (mem[r] != '0) n++;
    return n;
  endfunction
  task automatic run(input int restart_at, input int rst_at);
    done_k = 0;
    dcnt = 0;
    wcnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      rst = 1'b0;
      if (rst_at > 0 && k == rst_at + 1) begin
        check("rst_busy", W'(busy), '0);
        check("rst_we", W'(ram_we), '0);
        check("rst_lines", W'(lines_cleared), '0);
      end
      if (done) begin
        dcnt++;
        if (done_k == 0) begin
          done_k = k;
          lc_done = lines_cleared;
          sc_done = score_add;
        end
      end
      if (ram_we != '0) wcnt++;
      if (k == restart_at) start = 1'b1;
      if (k == rst_at) rst = 1'b1;
    end
  endtask
  task automatic load_case2();
    wipe();
    put(19, FULL);
    put(18, ROW_M);
  endtask
  task automatic check_case2(input string tag);
    check({tag, "_done_cnt"}, W'(dcnt), W'(1));
    check({tag, "_row19"}, mem[19], ROW_M);
    check({tag, "_upper"}, W'(nonempty(18)), '0);
    check({tag, "_lines"}, W'(lc_done), W'(1));
  endtask
  initial begin
    wipe();
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_lines", W'(lines_cleared), '0);
    check("reset_we", W'(ram_we), '0);
    check("reset_row", W'(ram_row), '0);
    check("reset_wdata", ram_wr_data, '0);
    rst = 1'b0;
    run(0, 0);
    check("empty_done_cycle", W'(done_k), W'(61));
    check("empty_done_cnt", W'(dcnt), W'(1));
    check("empty_writes", W'(wcnt), '0);
    check("empty_lines", W'(lc_done), '0);
    check("empty_board", W'(nonempty(31)), '0);
    load_case2();
    run(0, 0);
    check_case2("one");
    check("one_lines_held", W'(lines_cleared), W'(1));
    check("one_busy_after", W'(busy), '0);
`ifdef LINE_CLEAR_SCORE_EN
    check("one_score", W'(sc_done), W'(40));
`endif
    wipe();
    for (int r = 16; r <= 19; r++) put(r, FULL);
    put(15, ROW_P);
    run(0, 0);
    check("four_done_cnt", W'(dcnt), W'(1));
    check("four_row19", mem[19], ROW_P);
    check("four_upper", W'(nonempty(18)), '0);
    check("four_lines", W'(lc_done), W'(4));
`ifdef LINE_CLEAR_SCORE_EN
    check("four_score", W'(sc_done), W'(1200));
`endif
    wipe();
    put(19, FULL);
    put(18, ROW_A);
    put(17, FULL);
    put(16, ROW_B);
    run(0, 0);
    check("two_done_cnt", W'(dcnt), W'(1));
    check("two_row19", mem[19], ROW_A);
    check("two_row18", mem[18], ROW_B);
    check("two_upper", W'(nonempty(17)), '0);
    check("two_lines", W'(lc_done), W'(2));
`ifdef LINE_CLEAR_SCORE_EN
    check("two_score", W'(sc_done), W'(100));
`endif
    load_case2();
    run(0, 5);
    check("abort_no_done", W'(dcnt), '0);
    check("abort_idle", W'(busy), '0);
    load_case2();
    run(0, 0);
    check_case2("after_abort");
    load_case2();
    run(10, 0);
    check_case2("restart");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
